// File: rtl/acp_axi_responder.sv
// acp_axi_responder: AXI4 slave with a local byte-enabled 128-bit memory for 1- and 4-beat INCR bursts
module acp_axi_responder #(
    parameter int ADDR_WIDTH = 40,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [127:0]          s_axi_wdata,
    input  logic [15:0]           s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [127:0]          s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);
    localparam int IW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

    wstate_t       wst;
    rstate_t       rst_q;
    logic [127:0]  mem [MEM_WORDS];
    logic [IW-1:0] widx, ridx, waddr, raddr;
    logic [7:0]    wlen, wbeat, rlen, rbeat;
    logic          werr, rerr, we, w_final, w_bad;
    logic          unused_addr;

    assign waddr   = widx + IW'(wbeat);
    assign raddr   = ridx + IW'(rbeat);
    assign we      = s_axi_wvalid && s_axi_wready && !werr;
    assign w_final = wbeat == wlen;
    assign w_bad   = s_axi_wlast != w_final;
    assign unused_addr = ^{s_axi_awaddr[3:0], s_axi_awaddr[ADDR_WIDTH-1:IW+4],
                           s_axi_araddr[3:0], s_axi_araddr[ADDR_WIDTH-1:IW+4]};

    // Byte-enabled memory write; contents survive reset
    always_ff @(posedge clk)
        if (we)
            for (int i = 0; i < 16; i++)
                if (s_axi_wstrb[i]) mem[waddr][8*i +: 8] <= s_axi_wdata[8*i +: 8];

    // Write channel FSM: accept AW, count len+1 beats, then hold B until taken
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wst           <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= 2'b00;
            widx          <= '0;
            wlen          <= '0;
            wbeat         <= '0;
            werr          <= 1'b0;
        end else begin
            case (wst)
                W_IDLE:
                    if (!s_axi_awready) s_axi_awready <= 1'b1;
                    else if (s_axi_awvalid) begin
                        widx          <= s_axi_awaddr[IW+3:4];
                        wlen          <= s_axi_awlen;
                        werr          <= !(s_axi_awlen == 8'd0 || s_axi_awlen == 8'd3);
                        wbeat         <= '0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        wst           <= W_DATA;
                    end
                W_DATA:
                    if (s_axi_wvalid) begin
                        wbeat <= wbeat + 8'd1;
                        if (w_bad) werr <= 1'b1;
                        if (w_final) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= (werr || w_bad) ? 2'b10 : 2'b00;
                            wst          <= W_RESP;
                        end
                    end
                W_RESP:
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_bresp   <= 2'b00;
                        s_axi_awready <= 1'b1;
                        wst           <= W_IDLE;
                    end
                default: wst <= W_IDLE;
            endcase
        end

    // Read channel FSM: one fetch cycle per beat, error bursts return zeros with SLVERR
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rst_q         <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rresp   <= 2'b00;
            s_axi_rdata   <= '0;
            ridx          <= '0;
            rlen          <= '0;
            rbeat         <= '0;
            rerr          <= 1'b0;
        end else begin
            case (rst_q)
                R_IDLE:
                    if (!s_axi_arready) s_axi_arready <= 1'b1;
                    else if (s_axi_arvalid) begin
                        ridx          <= s_axi_araddr[IW+3:4];
                        rlen          <= s_axi_arlen;
                        rerr          <= !(s_axi_arlen == 8'd0 || s_axi_arlen == 8'd3);
                        rbeat         <= '0;
                        s_axi_arready <= 1'b0;
                        rst_q         <= R_FETCH;
                    end
                R_FETCH: begin
                    s_axi_rdata  <= rerr ? '0 : mem[raddr];
                    s_axi_rresp  <= rerr ? 2'b10 : 2'b00;
                    s_axi_rlast  <= rbeat == rlen;
                    s_axi_rvalid <= 1'b1;
                    rst_q        <= R_DATA;
                end
                R_DATA:
                    if (s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                        s_axi_rlast  <= 1'b0;
                        rbeat        <= rbeat + 8'd1;
                        if (s_axi_rlast) begin
                            s_axi_arready <= 1'b1;
                            rst_q         <= R_IDLE;
                        end else rst_q <= R_FETCH;
                    end
                default: rst_q <= R_IDLE;
            endcase
        end
endmodule

// File: tb/tb_acp_axi_responder.sv
// tb_acp_axi_responder: directed self-checking bench for acp_axi_responder
module tb_acp_axi_responder;
    logic         clk = 0, rst = 1;
    logic [39:0]  s_axi_awaddr = '0, s_axi_araddr = '0;
    logic [7:0]   s_axi_awlen = '0, s_axi_arlen = '0;
    logic         s_axi_awvalid = 0, s_axi_awready;
    logic [127:0] s_axi_wdata = '0, s_axi_rdata;
    logic [15:0]  s_axi_wstrb = '0;
    logic         s_axi_wlast = 0, s_axi_wvalid = 0, s_axi_wready;
    logic [1:0]   s_axi_bresp, s_axi_rresp;
    logic         s_axi_bvalid, s_axi_bready = 0;
    logic         s_axi_arvalid = 0, s_axi_arready;
    logic         s_axi_rlast, s_axi_rvalid, s_axi_rready = 0;

    int n_chk = 0, n_fail = 0;
    logic [127:0] wd [4];
    logic [127:0] rd_exp [4];

    acp_axi_responder #(.ADDR_WIDTH(40), .MEM_WORDS(1024)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_aw(input logic [39:0] a, input logic [7:0] l);
        int n = 0;
        s_axi_awaddr = a; s_axi_awlen = l; s_axi_awvalid = 1;
        while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("aw_timeout", 0, 1);
        @(negedge clk);
        s_axi_awvalid = 0;
    endtask

    task automatic do_w(input logic [127:0] d, input logic [15:0] s, input logic l);
        int n = 0;
        s_axi_wdata = d; s_axi_wstrb = s; s_axi_wlast = l; s_axi_wvalid = 1;
        while (!s_axi_wready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("w_timeout", 0, 1);
        @(negedge clk);
        s_axi_wvalid = 0; s_axi_wlast = 0;
    endtask

    task automatic write_burst(input logic [39:0] a, input logic [7:0] l, input logic [15:0] s,
                               input logic [3:0] lastmask, input logic [1:0] resp);
        int n = 0;
        do_aw(a, l);
        for (int b = 0; b <= int'(l); b++) do_w(wd[b], s, lastmask[b]);
        check("b_lat", s_axi_bvalid, 1);
        s_axi_bready = 1;
        while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
        check("bresp", s_axi_bresp, resp);
        @(negedge clk);
        s_axi_bready = 0;
        check("b_drop", s_axi_bvalid, 0);
    endtask

    task automatic read_burst(input logic [39:0] a, input logic [7:0] l, input logic [1:0] resp,
                              input logic stall);
        int n;
        s_axi_araddr = a; s_axi_arlen = l; s_axi_arvalid = 1;
        n = 0;
        while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("ar_timeout", 0, 1);
        @(negedge clk);
        s_axi_arvalid = 0;
        for (int b = 0; b <= int'(l); b++) begin
            n = 0;
            while (!s_axi_rvalid && n < 20) begin @(negedge clk); n++; end
            check("r_lat", n, 1);
            check("rdata", s_axi_rdata, rd_exp[b]);
            check("rresp", s_axi_rresp, resp);
            check("rlast", s_axi_rlast, b == int'(l));
            if (stall) begin
                @(negedge clk);
                check("r_hold_v", s_axi_rvalid, 1);
                check("r_hold_d", s_axi_rdata, rd_exp[b]);
                check("r_hold_l", s_axi_rlast, b == int'(l));
            end
            s_axi_rready = 1;
            @(negedge clk);
            s_axi_rready = 0;
        end
    endtask

    task automatic read1(input logic [39:0] a, input logic [127:0] exp);
        rd_exp[0] = exp;
        read_burst(a, 8'd0, 2'b00, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ctl", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
                          s_axi_rvalid, s_axi_rlast, s_axi_rresp}, 0);
        check("rst_rdata", s_axi_rdata, 0);
        rst = 0;
        @(negedge clk);

        // single-beat write and readback
        wd[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        write_burst(40'h40, 8'd0, 16'hFFFF, 4'b0001, 2'b00);
        read1(40'h40, 128'h00112233_44556677_8899AABB_CCDDEEFF);

        // partial strobe on word 4
        wd[0] = {128{1'b1}};
        write_burst(40'h40, 8'd0, 16'hFFFF, 4'b0001, 2'b00);
        wd[0] = '0;
        write_burst(40'h40, 8'd0, 16'h000F, 4'b0001, 2'b00);
        read1(40'h40, {{96{1'b1}}, 32'h0});

        // four-beat burst with stalled readback
        for (int b = 0; b < 4; b++) begin wd[b] = 128'(b + 1); rd_exp[b] = 128'(b + 1); end
        write_burst(40'h100, 8'd3, 16'hFFFF, 4'b1000, 2'b00);
        read_burst(40'h100, 8'd3, 2'b00, 1);

        // wrap at the top of memory: words 1022, 1023, 0, 1
        for (int b = 0; b < 4; b++) begin
            wd[b] = {32'hA0A0_0000 + 32'(b), 96'h5};
            rd_exp[b] = wd[b];
        end
        write_burst(40'h3FE0, 8'd3, 16'hFFFF, 4'b1000, 2'b00);
        read_burst(40'h3FE0, 8'd3, 2'b00, 0);
        read1(40'h0, {32'hA0A0_0002, 96'h5});
        read1(40'h10, {32'hA0A0_0003, 96'h5});

        // unsupported awlen=1: two beats consumed, memory untouched
        wd[0] = 128'hC0DE_0032; write_burst(40'h200, 8'd0, 16'hFFFF, 4'b0001, 2'b00);
        wd[0] = 128'hC0DE_0033; write_burst(40'h210, 8'd0, 16'hFFFF, 4'b0001, 2'b00);
        wd[0] = 128'hBAD0; wd[1] = 128'hBAD1;
        write_burst(40'h200, 8'd1, 16'hFFFF, 4'b0010, 2'b10);
        read1(40'h200, 128'hC0DE_0032);
        read1(40'h210, 128'hC0DE_0033);

        // early wlast on beat 0: beat 0 written, SLVERR
        for (int b = 0; b < 4; b++) wd[b] = 128'hE000 + 128'(b);
        write_burst(40'h300, 8'd3, 16'hFFFF, 4'b1001, 2'b10);
        read1(40'h300, 128'hE000);

        // unsupported arlen=2: three zero beats with SLVERR
        for (int b = 0; b < 4; b++) rd_exp[b] = '0;
        read_burst(40'h100, 8'd2, 2'b10, 0);

        // reset in the middle of a write burst
        do_aw(40'h500, 8'd3);
        do_w(128'hF0, 16'hFFFF, 0);
        do_w(128'hF1, 16'hFFFF, 0);
        rst = 1;
        #1;
        check("mid_rst_ctl", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
                              s_axi_rvalid, s_axi_rlast, s_axi_rresp}, 0);
        check("mid_rst_rdata", s_axi_rdata, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("post_rst_awready", s_axi_awready, 1);
        check("post_rst_bvalid", s_axi_bvalid, 0);
        read1(40'h500, 128'hF0);
        read1(40'h510, 128'hF1);
        wd[0] = 128'h1234;
        write_burst(40'h600, 8'd0, 16'hFFFF, 4'b0001, 2'b00);
        read1(40'h600, 128'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
